// File: rtl/pipe_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: none (definitions only).
// Backpressure: n/a.
package pipe_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        FULL  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] DEF_HALT_ADDR    = 32'h0000_0000;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pipe_if_id_reg.sv
// IF/ID pipeline register: instruction, its PC and a real-instruction flag.
// Latency: one cycle from load/bubble to outputs.
// Backpressure: holds contents whenever neither load nor bubble is asserted.
module pipe_if_id_reg
    import pipe_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instr_dat,
    input  logic [31:0] pc_dat,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_fetched
);

    // A bubble keeps the old PC; only the instruction and the valid flag change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_instr   <= NOP_INSTR;
            id_pc      <= 32'h0;
            id_fetched <= 1'b0;
        end else if (load) begin
            id_instr   <= instr_dat;
            id_pc      <= pc_dat;
            id_fetched <= 1'b1;
        end else if (bubble) begin
            id_instr   <= NOP_INSTR;
            id_fetched <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_fetch_stage.sv
// IF stage: owns the PC, reads instructions over the shared bus and feeds the IF/ID register.
// Latency: zero-wait read lands in IF/ID on the next edge; one instruction per cycle when unstalled.
// Backpressure: a word returned during a stall is parked in a one-entry buffer; no new read until it drains.
module pipe_fetch_stage
    import pipe_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] HALT_ADDR    = DEF_HALT_ADDR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        FetchMemSel,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] fetch_address,
    output logic        fetch_read,
    output logic        fetch_busy,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PC,
    output logic        IF_ID_Fetched,
    output logic        active
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic [31:0]  buf_dat;
    logic [31:0]  pend_target;
    logic         pend_vld;
    logic         advance;
    logic         req_issue;
    logic         rd_done;
    logic         word_vld;
    logic [31:0]  word_dat;
    logic         pc_load;
    logic         buf_load;

    assign advance   = PCWrite & IF_ID_Write;
    assign req_issue = (state == FETCH) && (pc != HALT_ADDR) && FetchMemSel;

    // Gating with reset_n drops the request in the same cycle reset is asserted.
    assign fetch_read    = reset_n && (req_issue || (state == WAIT));
    assign fetch_busy    = fetch_read;
    assign fetch_address = pc;

    assign rd_done  = fetch_read && !waitrequest;
    assign word_vld = rd_done || (state == FULL);
    assign word_dat = (state == FULL) ? buf_dat : readdata;
    assign pc_load  = advance && word_vld;
    assign buf_load = rd_done && !advance;

    // The word at PC is always the one delivered, so a redirect takes effect
    // only after the delay slot leaves IF.
    assign next_pc = branch_taken ? branch_target :
                     pend_vld     ? pend_target   :
                                    pc_inc(pc);

    assign active = (state != HALT);

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: begin
                if (pc == HALT_ADDR) begin
                    state_nxt = HALT;
                end else if (FetchMemSel) begin
                    if (rd_done) begin
                        state_nxt = advance ? FETCH : FULL;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (rd_done) begin
                    state_nxt = advance ? FETCH : FULL;
                end
            end
            FULL: begin
                if (advance) begin
                    state_nxt = FETCH;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_VECTOR;
        end else if (pc_load) begin
            pc <= next_pc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_dat <= NOP_INSTR;
        end else if (buf_load) begin
            buf_dat <= readdata;
        end
    end

    // A redirect that arrives while the PC is frozen is remembered until the next PC update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_vld    <= 1'b0;
            pend_target <= 32'h0;
        end else if (pc_load) begin
            pend_vld    <= 1'b0;
        end else if (branch_taken) begin
            pend_vld    <= 1'b1;
            pend_target <= branch_target;
        end
    end

    pipe_if_id_reg u_if_id (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (pc_load),
        .bubble     (advance && !word_vld),
        .instr_dat  (word_dat),
        .pc_dat     (pc),
        .id_instr   (IF_ID_Instruction),
        .id_pc      (IF_ID_PC),
        .id_fetched (IF_ID_Fetched)
    );

endmodule
